// File: rtl/sample_buffer_ctrl.sv
//------------------------------------------------------------------------------
// Module   : sample_buffer_ctrl
// Purpose  : Frame buffer for IO samples with a CPU read window and status word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sample_buffer_ctrl #(
  parameter int          DATA_W    = 8,
  parameter int          DEPTH     = 256,
  parameter int          ADDR_W    = 8,
  parameter logic [15:0] BASE_ADDR = 16'h5500,
  parameter logic [15:0] STAT_ADDR = 16'h5002
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              write_Buffer,
  input  logic [DATA_W-1:0] data_wr,
  input  logic              acknowledged,
  input  logic [15:0]       address,
  input  logic              read_IO,
  output logic [15:0]       data_read_out,
  output logic              read_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic              interrupt
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_interrupt;
  logic [15:0]       r_rdata;
  logic              r_rvalid;

  logic              w_full;
  logic              w_wr_accept;
  logic              w_wr_drop;
  logic [ADDR_W-1:0] w_idx;
  logic              w_win_hit;
  logic              w_stat_hit;
  logic              w_idx_valid;
  logic [31:0]       w_cnt_ext;
  logic [15:0]       w_status;

  assign w_full      = (r_count == c_depth);
  assign w_wr_accept = write_Buffer && !w_full && !acknowledged;
  assign w_wr_drop   = write_Buffer &&  w_full && !acknowledged;

  // Base address is DEPTH-aligned, so the window hit reduces to an upper-bit match.
  assign w_idx       = address[ADDR_W-1:0];
  assign w_win_hit   = read_IO && (address[15:ADDR_W] == BASE_ADDR[15:ADDR_W]);
  assign w_stat_hit  = read_IO && (address == STAT_ADDR);
  assign w_idx_valid = ({1'b0, w_idx} < r_count);
  assign w_cnt_ext   = 32'(r_count);
  assign w_status    = {r_overflow, w_full, 5'b0, w_cnt_ext[8:0]};

  // Sample storage carries no reset; stale entries are masked by the count.
  always_ff @(posedge clk) begin
    if (w_wr_accept && !rst) begin
      r_mem[r_count[ADDR_W-1:0]] <= data_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_interrupt <= 1'b0;
    end else if (acknowledged) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_interrupt <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_count <= r_count + 1'b1;
        if (r_count == c_depth - 1'b1) begin
          r_interrupt <= 1'b1;
        end
      end
      if (w_wr_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Reads see pre-edge state, so an entry being written this cycle reads as empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else if (w_stat_hit) begin
      r_rdata  <= w_status;
      r_rvalid <= 1'b1;
    end else if (w_win_hit) begin
      r_rdata  <= w_idx_valid ? 16'(r_mem[w_idx]) : 16'h0000;
      r_rvalid <= 1'b1;
    end else begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end
  end

  assign data_read_out = r_rdata;
  assign read_valid    = r_rvalid;
  assign count         = r_count;
  assign full          = w_full;
  assign overflow      = r_overflow;
  assign interrupt     = r_interrupt;

endmodule

`default_nettype wire

// File: tb/tb_sample_buffer_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_sample_buffer_ctrl
// Purpose  : Directed self-checking bench for sample_buffer_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sample_buffer_ctrl;

  logic        clk;
  logic        rst;
  logic        write_Buffer;
  logic [7:0]  data_wr;
  logic        acknowledged;
  logic [15:0] address;
  logic        read_IO;
  logic [15:0] data_read_out;
  logic        read_valid;
  logic [8:0]  count;
  logic        full;
  logic        overflow;
  logic        interrupt;

  int total = 0;
  int bad   = 0;

  sample_buffer_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .write_Buffer (write_Buffer),
    .data_wr      (data_wr),
    .acknowledged (acknowledged),
    .address      (address),
    .read_IO      (read_IO),
    .data_read_out(data_read_out),
    .read_valid   (read_valid),
    .count        (count),
    .full         (full),
    .overflow     (overflow),
    .interrupt    (interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic wr(input logic [7:0] d);
    write_Buffer = 1'b1;
    data_wr      = d;
    @(negedge clk);
    write_Buffer = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [15:0] a, input logic ev, input logic [15:0] ed);
    address = a;
    read_IO = 1'b1;
    @(negedge clk);
    read_IO = 1'b0;
    chk({tag, "_valid"}, 32'(read_valid), 32'(ev));
    chk({tag, "_data"}, 32'(data_read_out), 32'(ed));
  endtask

  task automatic ack;
    acknowledged = 1'b1;
    @(negedge clk);
    acknowledged = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_Buffer = 1'b0; data_wr = '0; acknowledged = 1'b0;
    address = '0; read_IO = 1'b0;

    // 1: reset and idle status
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_count", 32'(count), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_irq", 32'(interrupt), 0);
    chk("rst_rvalid", 32'(read_valid), 0);
    chk("rst_rdata", 32'(data_read_out), 0);
    rd("stat0", 16'h5002, 1'b1, 16'h0000);

    // 2: full frame of ramp data
    for (int i = 0; i < 255; i++) wr(8'(i));
    chk("c255_count", 32'(count), 255);
    chk("c255_full", 32'(full), 0);
    chk("c255_irq", 32'(interrupt), 0);
    wr(8'hFF);
    chk("c256_count", 32'(count), 256);
    chk("c256_full", 32'(full), 1);
    chk("c256_irq", 32'(interrupt), 1);
    rd("rd00", 16'h5500, 1'b1, 16'h0000);
    rd("rd80", 16'h5580, 1'b1, 16'h0080);
    rd("rdFF", 16'h55FF, 1'b1, 16'h00FF);
    rd("stat_full", 16'h5002, 1'b1, 16'h4100);

    // 3: overflow
    repeat (3) wr(8'h77);
    chk("ovf_count", 32'(count), 256);
    chk("ovf_flag", 32'(overflow), 1);
    rd("stat_ovf", 16'h5002, 1'b1, 16'hC100);
    rd("ovf_mem0", 16'h5500, 1'b1, 16'h0000);
    ack;
    chk("ack_count", 32'(count), 0);
    chk("ack_ovf", 32'(overflow), 0);
    chk("ack_irq", 32'(interrupt), 0);

    // 4: partial frame, bounds and read-before-write
    for (int i = 0; i < 10; i++) wr(8'hA0 + 8'(i));
    rd("p_rd9", 16'h5509, 1'b1, 16'h00A9);
    rd("p_rdA", 16'h550A, 1'b1, 16'h0000);
    rd("p_out", 16'h5600, 1'b0, 16'h0000);
    rd("p_stat", 16'h5002, 1'b1, 16'h000A);
    address = 16'h550A; read_IO = 1'b1;
    wr(8'h3C);
    read_IO = 1'b0;
    chk("rbw_data", 32'(data_read_out), 0);
    rd("rbw_after", 16'h550A, 1'b1, 16'h003C);
    ack;

    // 5: acknowledge colliding with a write on a full frame
    for (int i = 0; i < 256; i++) wr(8'(i) ^ 8'h33);
    chk("f5_irq", 32'(interrupt), 1);
    acknowledged = 1'b1;
    wr(8'hEE);
    acknowledged = 1'b0;
    chk("col_irq", 32'(interrupt), 0);
    chk("col_full", 32'(full), 0);
    chk("col_count", 32'(count), 0);
    chk("col_ovf", 32'(overflow), 0);
    wr(8'h5A);
    rd("col_rd", 16'h5500, 1'b1, 16'h005A);
    ack;

    // 6: reset mid-frame
    for (int i = 0; i < 100; i++) wr(8'(i) + 8'h10);
    rst = 1'b1; address = 16'h5500; read_IO = 1'b1;
    @(negedge clk);
    rst = 1'b0; read_IO = 1'b0;
    chk("mr_count", 32'(count), 0);
    chk("mr_rvalid", 32'(read_valid), 0);
    rd("mr_rd10", 16'h5510, 1'b1, 16'h0000);
    wr(8'h11);
    chk("mr_count1", 32'(count), 1);
    rd("mr_rd0", 16'h5500, 1'b1, 16'h0011);
    rd("mr_rd1", 16'h5501, 1'b1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
